// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit for the EX stage.
// MULT/MULTU use shift-add and DIV/DIVU use restoring division. Both work on
// operand magnitudes, one bit per cycle for 32 cycles. A final FIX cycle
// restores the signs and writes HI/LO together.
module ex_muldiv (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic        mf_req,
    output logic        busy,
    output logic        done,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t      state;
    logic [5:0]  iterCnt;
    logic        isDiv;
    logic        negQuo;     // product or quotient needs negation
    logic        negRem;     // remainder takes the dividend's sign
    logic        divZero;
    logic [31:0] addend;     // multiplicand magnitude or divisor magnitude
    logic [31:0] accHi;      // product high half or partial remainder
    logic [31:0] accLo;      // multiplier/product low half or dividend/quotient

    logic [32:0] mulSum;
    logic [32:0] divShift;
    logic [32:0] divTrial;

    // Two's-complement magnitude of an operand when the op is signed.
    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic signedOp);
        logic signed [31:0] sv;
        sv = signed'(v);
        return (signedOp && sv < 0) ? 32'(-sv) : v;
    endfunction

    // Conditional 32-bit negation used to restore a quotient or remainder sign.
    function automatic logic [31:0] applySign32(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    // Conditional 64-bit negation used to restore the product sign.
    function automatic logic [63:0] applySign64(input logic [63:0] v, input logic neg);
        return neg ? (~v + 64'd1) : v;
    endfunction

    // Per-iteration arithmetic: one shift-add step and one restoring-divide step.
    always_comb begin
        mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, addend} : 33'd0);
        divShift = {accHi, accLo[31]};
        divTrial = divShift - {1'b0, addend};
    end

    assign busy  = (state != IDLE);
    assign stall = busy & (start | mf_req | mthi | mtlo);

    // Control FSM, iteration datapath and HI/LO write-back.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            iterCnt <= 6'd0;
            done    <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            isDiv   <= 1'b0;
            negQuo  <= 1'b0;
            negRem  <= 1'b0;
            divZero <= 1'b0;
            addend  <= 32'd0;
            accHi   <= 32'd0;
            accLo   <= 32'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        iterCnt <= 6'd0;
                        isDiv   <= op[1];
                        negQuo  <= ~op[0] & (rs_data[31] ^ rt_data[31]);
                        negRem  <= ~op[0] & rs_data[31];
                        divZero <= (rt_data == 32'd0);
                        accHi   <= 32'd0;
                        accLo   <= op[1] ? magnitude(rs_data, ~op[0]) : magnitude(rt_data, ~op[0]);
                        addend  <= op[1] ? magnitude(rt_data, ~op[0]) : magnitude(rs_data, ~op[0]);
                    end else begin
                        if (mthi) hi <= rs_data;
                        if (mtlo) lo <= rs_data;
                    end
                end
                RUN: begin
                    iterCnt <= iterCnt + 6'd1;
                    if (isDiv) begin
                        // A borrow out of the trial subtraction means restore.
                        accHi <= divTrial[32] ? divShift[31:0] : divTrial[31:0];
                        accLo <= {accLo[30:0], ~divTrial[32]};
                    end else begin
                        {accHi, accLo} <= {mulSum, accLo[31:1]};
                    end
                    if (iterCnt == 6'd31) state <= FIX;
                end
                FIX: begin
                    state <= IDLE;
                    done  <= 1'b1;
                    if (isDiv) begin
                        // A zero divisor leaves the quotient all ones. The
                        // sign-restored remainder then equals the original dividend.
                        lo <= divZero ? 32'hFFFF_FFFF : applySign32(accLo, negQuo);
                        hi <= applySign32(accHi, negRem);
                    end else begin
                        {hi, lo} <= applySign64({accHi, accLo}, negQuo);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 Parameters: none; datapath width fixed at 32 bits, iteration count fixed at 32.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a multiply/divide from the ID/EX register outputs.
REQ-005 op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 rs_data  input  32  operand A (multiplicand / dividend).
REQ-007 rt_data  input  32  operand B (multiplier / divisor).
REQ-008 mthi  input  1  write rs_data into HI.
REQ-009 mtlo  input  1  write rs_data into LO.
REQ-010 mf_req  input  1  instruction in EX reads HI or LO (MFHI/MFLO).
REQ-011 busy  output  1  operation in progress.
REQ-012 done  output  1  one-cycle pulse, result committed to HI/LO.
REQ-013 stall  output  1  hold IF/ID/EX pipeline registers.
REQ-014 hi  output  32  HI register.
REQ-015 lo  output  32  LO register.

Function
REQ-016 FSM states SHALL be IDLE, RUN, FIX; IDLE->RUN on start while IDLE; RUN->FIX after 32 iterations; FIX->IDLE unconditionally.
REQ-017 Start SHALL be accepted only in IDLE; operands and op latched at the accepting edge.
REQ-018 RUN SHALL perform exactly 32 iterations on operand magnitudes (one bit per cycle), counted by a 6-bit counter.
REQ-019 Multiply SHALL be unsigned shift-add; divide SHALL be unsigned restoring division.
REQ-020 Signed ops (MULT, DIV) SHALL take magnitudes at start and apply sign correction in FIX.
REQ-021 Multiply result: HI = product[63:32], LO = product[31:0].
REQ-022 Divide result: LO = quotient, HI = remainder; truncation toward zero; remainder sign equals dividend sign.
REQ-023 Divide by zero (any sign) SHALL complete in normal latency with LO = 0xFFFFFFFF, HI = rs_data as latched.
REQ-024 DIV 0x80000000 / 0xFFFFFFFF SHALL yield LO = 0x80000000, HI = 0x00000000 (wrap, no trap).
REQ-025 HI and LO SHALL hold prior values during RUN; both SHALL be written together only at the FIX edge.
REQ-026 busy SHALL be high in RUN and FIX: 33 cycles, starting the cycle after the accepting edge.
REQ-027 done SHALL be high for exactly the one cycle after the FIX edge (first IDLE cycle), otherwise low.
REQ-028 stall SHALL be combinational: busy AND (start OR mf_req OR mthi OR mtlo).
REQ-029 start while busy SHALL be ignored; no restart, no operand relatch.
REQ-030 mthi/mtlo SHALL take effect in IDLE only; if start is asserted in the same cycle, start wins and mthi/mtlo are ignored.
REQ-031 mthi and mtlo together SHALL write rs_data into both HI and LO.
REQ-032 A start accepted in the done cycle SHALL be legal (back-to-back operations).

Reset
REQ-033 reset SHALL force state IDLE, counter 0, busy 0, done 0, HI 0x00000000, LO 0x00000000, internal operand/accumulator registers 0.
REQ-034 reset SHALL take priority over start, mthi, mtlo and any in-flight operation; the aborted operation produces no done and no HI/LO write.
REQ-035 A start asserted in the first cycle after reset deasserts SHALL be accepted.

Verification
REQ-036 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy for 33 cycles; done on cycle 34 after the accepting edge; HI = 0xFFFFFFFE, LO = 0x00000001.
REQ-037 MULT 0xFFFFFFFD (-3) x 0x00000007 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
REQ-038 DIV 0xFFFFFFF9 (-7) / 0x00000002 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF; DIVU 5 / 0 -> LO = 0xFFFFFFFF, HI = 0x00000005.
REQ-039 reset asserted at RUN iteration 10 of a MULT -> next cycle busy 0, done 0, HI = LO = 0; a subsequent start completes normally.
REQ-040 start + mf_req while busy -> stall 1 each such cycle, HI/LO unchanged until FIX, operation not restarted, exactly one done pulse.
REQ-041 mthi with rs_data 0x12345678 in IDLE -> HI = 0x12345678 next cycle, LO unchanged; mthi while busy -> stall 1, HI unchanged.
